// File: rtl/pixel_dispatcher.sv
// Frame walker: issues every pixel's complex coordinate to a depth calculator and streams depths out.
// Optional WAIT watchdog and sticky timeout_err port compiled in with PIXEL_DISPATCHER_TIMEOUT_EN.
module pixel_dispatcher #(
  parameter int FRAC        = 28,
  parameter int WORD_LENGTH = 32,
  parameter int H_RES       = 640,
  parameter int V_RES       = 480
) (
  input  logic                   sysclk,
  input  logic                   reset,
  input  logic                   run,
  input  logic [WORD_LENGTH-1:0] re_start,
  input  logic [WORD_LENGTH-1:0] im_start,
  input  logic [WORD_LENGTH-1:0] step,
  input  logic [9:0]             max_iter_in,
  output logic                   calc_start,
  output logic [9:0]             calc_x,
  output logic [8:0]             calc_y,
  output logic [WORD_LENGTH-1:0] calc_re_c,
  output logic [WORD_LENGTH-1:0] calc_im_c,
  output logic [9:0]             calc_max_iter,
  input  logic                   calc_done,
  input  logic [9:0]             calc_depth,
  output logic                   px_valid,
  input  logic                   px_ready,
  output logic [9:0]             px_depth,
  output logic                   px_sof,
  output logic                   px_eol,
  output logic                   frame_done,
`ifdef PIXEL_DISPATCHER_TIMEOUT_EN
  output logic                   timeout_err,
`endif
  output logic                   busy
);

  if (FRAC >= WORD_LENGTH) begin : g_bad_frac
    $error("pixel_dispatcher: FRAC must be smaller than WORD_LENGTH");
  end

  localparam logic [9:0] X_LAST = 10'(H_RES - 1);
  localparam logic [8:0] Y_LAST = 9'(V_RES - 1);

  typedef enum logic [2:0] {IDLE, LOAD, ISSUE, WAIT, OUTPUT} state_t;

  state_t                 state, state_n;
  logic                   done_q;
  logic                   done_edge;
  logic                   wd_expire;
  logic                   x_last, y_last;
  logic [WORD_LENGTH-1:0] re_base;
  logic [WORD_LENGTH-1:0] step_q;

  // Only a fresh 0->1 transition completes a pixel; a level held over from the last one is ignored.
  assign done_edge = calc_done & ~done_q;
  assign x_last    = (calc_x == X_LAST);
  assign y_last    = (calc_y == Y_LAST);

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (run) state_n = LOAD;
      LOAD:    state_n = ISSUE;
      ISSUE:   state_n = WAIT;
      WAIT:    if (done_edge || wd_expire) state_n = OUTPUT;
      OUTPUT:  if (px_ready) state_n = (x_last && y_last) ? IDLE : ISSUE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    calc_start = (state == ISSUE);
    px_valid   = (state == OUTPUT);
    px_sof     = (state == OUTPUT) && (calc_x == '0) && (calc_y == '0);
    px_eol     = (state == OUTPUT) && x_last;
    busy       = (state != IDLE);
  end

  // Coordinates are plain two's-complement words; adds and subtracts wrap.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      done_q        <= 1'b0;
      calc_x        <= '0;
      calc_y        <= '0;
      calc_re_c     <= '0;
      calc_im_c     <= '0;
      calc_max_iter <= '0;
      re_base       <= '0;
      step_q        <= '0;
      px_depth      <= '0;
      frame_done    <= 1'b0;
    end else begin
      done_q     <= calc_done;
      frame_done <= 1'b0;
      case (state)
        LOAD: begin
          calc_x        <= '0;
          calc_y        <= '0;
          calc_re_c     <= re_start;
          calc_im_c     <= im_start;
          calc_max_iter <= max_iter_in;
          re_base       <= re_start;
          step_q        <= step;
        end
        WAIT: begin
          if (done_edge)      px_depth <= calc_depth;
          else if (wd_expire) px_depth <= calc_max_iter;
        end
        OUTPUT: begin
          if (px_ready) begin
            if (!x_last) begin
              calc_x    <= calc_x + 10'd1;
              calc_re_c <= calc_re_c + step_q;
            end else if (!y_last) begin
              calc_x    <= '0;
              calc_y    <= calc_y + 9'd1;
              calc_re_c <= re_base;
              calc_im_c <= calc_im_c - step_q;
            end else begin
              frame_done <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifdef PIXEL_DISPATCHER_TIMEOUT_EN
  logic [11:0] wd_cnt;

  // Cleared in ISSUE so it reads zero on the first WAIT cycle.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      wd_cnt      <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (state == ISSUE)                     wd_cnt <= '0;
      else if (state == WAIT && wd_cnt != '1) wd_cnt <= wd_cnt + 12'd1;
      if (wd_expire) timeout_err <= 1'b1;
    end
  end

  always_comb wd_expire = (state == WAIT) && !done_edge && (wd_cnt == '1);
`else
  always_comb wd_expire = 1'b0;
`endif

endmodule
